// File: rtl/round_sched.sv
// Two-requester arbiter feeding a single-cycle IEEE-style mantissa rounder with a valid/ready output.
// Define ROUND_SCHED_RR_ARB_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module round_sched #(
  parameter int unsigned Significant_WD  = 23,
  parameter int unsigned Exp_WD          = 8,
  parameter int unsigned roundmodeReg_WD = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [Significant_WD+3:0]   req0_sig,
  input  logic [Significant_WD+3:0]   req1_sig,
  input  logic [Exp_WD-1:0]           req0_exp,
  input  logic [Exp_WD-1:0]           req1_exp,
  input  logic                        req0_sign,
  input  logic                        req1_sign,
  input  logic [roundmodeReg_WD-1:0]  req0_mode,
  input  logic [roundmodeReg_WD-1:0]  req1_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [Significant_WD-1:0]   out_sig,
  output logic [Exp_WD-1:0]           out_exp,
  output logic                        out_sign,
  output logic                        out_inexact,
  output logic                        out_overflow,
  output logic                        out_src
);

  localparam int unsigned SigW = Significant_WD + 4;
  localparam int unsigned ManW = Significant_WD + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  logic [SigW-1:0]           cap_sig_q, cap_sig_d;
  logic [Exp_WD-1:0]         cap_exp_q, cap_exp_d;
  logic                      cap_sign_q, cap_sign_d;
  logic [1:0]                cap_mode_q, cap_mode_d;
  logic                      cap_src_q, cap_src_d;

  logic [Significant_WD-1:0] out_sig_q, out_sig_d;
  logic [Exp_WD-1:0]         out_exp_q, out_exp_d;
  logic                      out_sign_q, out_sign_d;
  logic                      out_inexact_q, out_inexact_d;
  logic                      out_overflow_q, out_overflow_d;
  logic                      out_src_q, out_src_d;

  logic grant_valid, grant_id, hs;

  // Arbitration
`ifdef ROUND_SCHED_RR_ARB_EN
  logic ptr_q, ptr_d;

  always_comb begin
    grant_id = 1'b0;
    unique case (req_valid)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ptr_q;
      default: grant_id = 1'b0;
    endcase
    ptr_d = hs ? ~grant_id : ptr_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb grant_id = (req_valid == 2'b10);
`endif

  always_comb begin
    grant_valid = |req_valid;
    req_ready   = 2'b00;
    if (state_q == StIdle && !RST && grant_valid) req_ready[grant_id] = 1'b1;
    hs = |(req_valid & req_ready);
  end

  // Rounding of the captured operand
  logic [ManW-1:0]           mant;
  logic [2:0]                guard;
  logic                      round_up, carry;
  logic [Exp_WD-1:0]         exp_inc;
  logic [Significant_WD-1:0] res_sig;
  logic [Exp_WD-1:0]         res_exp;
  logic                      res_ovf;

  always_comb begin
    mant     = cap_sig_q[SigW-1:3];
    guard    = cap_sig_q[2:0];
    round_up = 1'b0;
    unique case (cap_mode_q)
      2'b00: round_up = (guard > 3'b100) || (guard == 3'b100 && mant[0]);
      2'b01: round_up = 1'b0;
      2'b10: round_up = !cap_sign_q && (guard != 3'b000);
      2'b11: round_up = cap_sign_q && (guard != 3'b000);
      default: round_up = 1'b0;
    endcase
    // A carry out of the hidden bit wraps the stored mantissa to zero naturally.
    carry   = round_up && (&mant);
    exp_inc = cap_exp_q + Exp_WD'(1);
    res_sig = round_up ? mant[Significant_WD-1:0] + Significant_WD'(1)
                       : mant[Significant_WD-1:0];
    res_exp = carry ? exp_inc : cap_exp_q;
    res_ovf = carry && (&exp_inc);
  end

  always_comb begin
    state_d        = state_q;
    cap_sig_d      = cap_sig_q;
    cap_exp_d      = cap_exp_q;
    cap_sign_d     = cap_sign_q;
    cap_mode_d     = cap_mode_q;
    cap_src_d      = cap_src_q;
    out_sig_d      = out_sig_q;
    out_exp_d      = out_exp_q;
    out_sign_d     = out_sign_q;
    out_inexact_d  = out_inexact_q;
    out_overflow_d = out_overflow_q;
    out_src_d      = out_src_q;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          cap_sig_d  = grant_id ? req1_sig  : req0_sig;
          cap_exp_d  = grant_id ? req1_exp  : req0_exp;
          cap_sign_d = grant_id ? req1_sign : req0_sign;
          cap_mode_d = grant_id ? req1_mode[1:0] : req0_mode[1:0];
          cap_src_d  = grant_id;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        out_sig_d      = res_sig;
        out_exp_d      = res_exp;
        out_sign_d     = cap_sign_q;
        out_inexact_d  = |guard;
        out_overflow_d = res_ovf;
        out_src_d      = cap_src_q;
        state_d        = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= StIdle;
      cap_sig_q      <= '0;
      cap_exp_q      <= '0;
      cap_sign_q     <= 1'b0;
      cap_mode_q     <= '0;
      cap_src_q      <= 1'b0;
      out_sig_q      <= '0;
      out_exp_q      <= '0;
      out_sign_q     <= 1'b0;
      out_inexact_q  <= 1'b0;
      out_overflow_q <= 1'b0;
      out_src_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cap_sig_q      <= cap_sig_d;
      cap_exp_q      <= cap_exp_d;
      cap_sign_q     <= cap_sign_d;
      cap_mode_q     <= cap_mode_d;
      cap_src_q      <= cap_src_d;
      out_sig_q      <= out_sig_d;
      out_exp_q      <= out_exp_d;
      out_sign_q     <= out_sign_d;
      out_inexact_q  <= out_inexact_d;
      out_overflow_q <= out_overflow_d;
      out_src_q      <= out_src_d;
    end
  end

  assign out_valid    = (state_q == StDone);
  assign out_sig      = out_sig_q;
  assign out_exp      = out_exp_q;
  assign out_sign     = out_sign_q;
  assign out_inexact  = out_inexact_q;
  assign out_overflow = out_overflow_q;
  assign out_src      = out_src_q;

endmodule
